// File: rtl/sd_pkg.sv
// Shared definitions for the SD image loader: loader states, sector size
// and the sector-count helper used to size a load.
package sd_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int STATE_W      = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE,
      WAIT_INIT,
      REQ,
      RECV,
      GAP,
      FIN
   } state_t;

   // Number of whole sectors needed to hold the image (ceiling divide).
   function automatic int num_sec(input int pix_total, input int pix_bytes);
      return (pix_total * pix_bytes + SECTOR_BYTES - 1) / SECTOR_BYTES;
   endfunction

endpackage

// File: rtl/sd_byte_packer.sv
// Packs a byte stream into PIX_BYTES-wide pixel words. The first byte of a
// pixel ends up in the MSBs; word_valid pulses the cycle after the byte that
// completes a pixel. Partial pixels survive until clr or reset.
module sd_byte_packer
   import sd_pkg::*;
#(
   parameter  int PIX_BYTES = 2,
   localparam int DATA_W    = 8 * PIX_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word,
   output logic              word_valid
);

   logic [7:0] lane_reg [PIX_BYTES];
   logic [1:0] cnt_reg;
   logic       last;

   assign last = (cnt_reg == 2'(PIX_BYTES - 1));

   // Shift lanes toward the MSB lane; lane 0 always takes the newest byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIX_BYTES; i++) lane_reg[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < PIX_BYTES; i++) lane_reg[i] <= '0;
      end else if (en) begin
         for (int i = PIX_BYTES - 1; i > 0; i--) lane_reg[i] <= lane_reg[i-1];
         lane_reg[0] <= byte_in;
      end
   end

   // Count bytes modulo PIX_BYTES and flag a finished pixel one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         word_valid <= 1'b0;
      end else if (clr) begin
         cnt_reg    <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= en && last;
         if (en) cnt_reg <= last ? 2'd0 : cnt_reg + 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < PIX_BYTES; gi++) begin : g_word
         assign word[8*gi +: 8] = lane_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/sd_img_loader.sv
// Loads one contiguously stored image from the SD card into BRAM: walks the
// image's sectors through the SD reader, packs the returned bytes into
// pixels and writes them to consecutive BRAM addresses.
module sd_img_loader
   import sd_pkg::*;
#(
   parameter  int PIX_BYTES = 2,
   parameter  int PIX_TOTAL = 19200,
   parameter  int ADDR_W    = 15,
   localparam int DATA_W    = 8 * PIX_BYTES
) (
   input  logic              sd_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       base_sec,
   input  logic              init,
   input  logic [7:0]        sd_byte,
   input  logic              sd_valid,
   input  logic              sd_read_done,
   output logic              read_req,
   output logic [31:0]       sec,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam int              NUM_SEC  = num_sec(PIX_TOTAL, PIX_BYTES);
   localparam logic [31:0]     LAST_SEC = 32'(NUM_SEC - 1);
   localparam logic [ADDR_W:0] PIX_LIM  = (ADDR_W + 1)'(PIX_TOTAL);
   localparam logic [ADDR_W:0] PIX_ONE  = (ADDR_W + 1)'(1);

   state_t          state_reg, state_next;
   logic [31:0]     sec_cnt_reg;
   logic [8:0]      byte_cnt_reg;
   logic            sec_full_reg;   // 512 bytes of this sector already taken
   logic            gap_reg;        // second GAP cycle
   logic            rd_prev_reg;
   logic [ADDR_W:0] pix_cnt_reg;
   logic            accept, take, rd_rise, last_sec;
   logic            word_valid;
   logic [DATA_W-1:0] word;

   assign accept   = (state_reg == IDLE) && start;
   assign take     = (state_reg == RECV) && sd_valid && !sec_full_reg;
   assign rd_rise  = sd_read_done && !rd_prev_reg;
   assign last_sec = (sec_cnt_reg == LAST_SEC);

   sd_byte_packer #(.PIX_BYTES(PIX_BYTES)) u_packer (
      .clk        (sd_clk),
      .rst        (rst),
      .clr        (accept),
      .en         (take),
      .byte_in    (sd_byte),
      .word       (word),
      .word_valid (word_valid)
   );

   // Padding pixels past the image end are packed but never written.
   assign wr_en   = word_valid && (pix_cnt_reg < PIX_LIM);
   assign wr_addr = pix_cnt_reg[ADDR_W-1:0];
   assign wr_data = word;

   // State register.
   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state sequencing of the sector walk.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (start) state_next = init ? REQ : WAIT_INIT;
         WAIT_INIT: if (init) state_next = REQ;
         REQ:       state_next = RECV;
         RECV:      if (rd_rise) state_next = GAP;
         GAP:       if (gap_reg) state_next = last_sec ? FIN : REQ;
         FIN:       state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Sector address, byte/sector/pixel counters and status flags.
   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
         read_req     <= 1'b0;
         sec          <= '0;
         sec_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         sec_full_reg <= 1'b0;
         gap_reg      <= 1'b0;
         rd_prev_reg  <= 1'b0;
         pix_cnt_reg  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         rd_prev_reg <= sd_read_done;
         read_req    <= (state_next == REQ) || (state_next == RECV);
         gap_reg     <= (state_reg == GAP) ? !gap_reg : 1'b0;

         if (accept) begin
            sec          <= base_sec;
            sec_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            sec_full_reg <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
         end else if ((state_reg == GAP) && gap_reg && !last_sec) begin
            sec          <= sec + 32'd1;
            sec_cnt_reg  <= sec_cnt_reg + 32'd1;
            byte_cnt_reg <= '0;
            sec_full_reg <= 1'b0;
         end else if (take) begin
            if (byte_cnt_reg == 9'd511) sec_full_reg <= 1'b1;
            else                        byte_cnt_reg <= byte_cnt_reg + 9'd1;
         end

         if (state_reg == FIN) begin
            busy <= 1'b0;
            done <= 1'b1;
         end

         if (accept)     pix_cnt_reg <= '0;
         else if (wr_en) pix_cnt_reg <= pix_cnt_reg + PIX_ONE;
      end
   end

endmodule
